pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/gpu_pkg.sv | 28 ++
 rtl/pc_unit_if.sv | 60 ++++++
 rtl/pc_unit_rr_arbiter.sv | 31 +++
 rtl/pc_unit.sv | 137 +++++++++++++
 tb/tb_pc_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared PC-unit constants: default PC width, warp count, warp-id width and the
// per-warp PC update sources, whose encoding doubles as their priority order.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package gpu_pkg;

    localparam int PC_WIDTH  = `PC_WIDTH;
    localparam int NUM_WARPS = 4;

    function automatic int wid_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WID = wid_of(NUM_WARPS);

    // Larger value wins when several sources hit the same warp in one cycle.
    typedef enum logic [2:0] {
        UPD_HOLD   = 3'd0,
        UPD_INC    = 3'd1,
        UPD_RET    = 3'd2,
        UPD_BRANCH = 3'd3,
        UPD_HALT   = 3'd4,
        UPD_LAUNCH = 3'd5
    } upd_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Issue/control bundle between a warp scheduler front end and pc_unit.
// PC_UNIT_LINK_EN adds the branch-and-link / return request signals.
interface pc_unit_if
    import gpu_pkg::*;
#(
    parameter int PC_WIDTH  = `PC_WIDTH,
    parameter int NUM_WARPS = 4
);
    localparam int WID = wid_of(NUM_WARPS);

    logic                 en;
    logic                 stall;
    logic                 launch;
    logic [NUM_WARPS-1:0] launch_mask;
    logic                 branch_valid;
    logic [WID-1:0]       branch_warp;
    logic [PC_WIDTH-1:0]  branch_target;
    logic                 halt_valid;
    logic [WID-1:0]       halt_warp;
`ifdef PC_UNIT_LINK_EN
    logic                 branch_link;
    logic                 ret_valid;
    logic [WID-1:0]       ret_warp;
`endif
    logic [PC_WIDTH-1:0]  pc_out;
    logic [WID-1:0]       warp_id_out;
    logic                 valid_out;
    logic                 idle;

`ifdef PC_UNIT_LINK_EN
    modport master (
        output en, stall, launch, launch_mask,
        output branch_valid, branch_warp, branch_target,
        output halt_valid, halt_warp,
        output branch_link, ret_valid, ret_warp,
        input  pc_out, warp_id_out, valid_out, idle
    );
    modport slave (
        input  en, stall, launch, launch_mask,
        input  branch_valid, branch_warp, branch_target,
        input  halt_valid, halt_warp,
        input  branch_link, ret_valid, ret_warp,
        output pc_out, warp_id_out, valid_out, idle
    );
`else
    modport master (
        output en, stall, launch, launch_mask,
        output branch_valid, branch_warp, branch_target,
        output halt_valid, halt_warp,
        input  pc_out, warp_id_out, valid_out, idle
    );
    modport slave (
        input  en, stall, launch, launch_mask,
        input  branch_valid, branch_warp, branch_target,
        input  halt_valid, halt_warp,
        output pc_out, warp_id_out, valid_out, idle
    );
`endif

endinterface

// File: rtl/pc_unit_rr_arbiter.sv
// Round-robin pick of the first requester at or after ptr_i, wrapping around.
// Purely combinational; N must be a power of two so the index wraps naturally.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int WID = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [WID-1:0] ptr_i,
    output logic [N-1:0]   grant_o,
    output logic [WID-1:0] idx_o,
    output logic           vld_o
);

    logic [WID-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        vld_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_i + WID'(k);
            if (!vld_o && req_i[cand]) begin
                vld_o          = 1'b1;
                idx_o          = cand;
                grant_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Per-warp PC file with round-robin issue; one cycle from selection to pc_out.
// stall/en only gate issue; launch/branch/halt always apply. Link regs: PC_UNIT_LINK_EN.
module pc_unit
    import gpu_pkg::*;
#(
    parameter int                  PC_WIDTH  = `PC_WIDTH,
    parameter int                  NUM_WARPS = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic     clk,
    input  logic     rst,
    pc_unit_if.slave bus
);

    localparam int WID = wid_of(NUM_WARPS);

    logic [PC_WIDTH-1:0]  pc_q   [NUM_WARPS];
    logic [PC_WIDTH-1:0]  pc_d   [NUM_WARPS];
`ifdef PC_UNIT_LINK_EN
    logic [PC_WIDTH-1:0]  link_q [NUM_WARPS];
    logic [PC_WIDTH-1:0]  link_d [NUM_WARPS];
`endif
    logic [NUM_WARPS-1:0] live_q, live_d;
    logic [WID-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PC_WIDTH-1:0]  pc_out_q, pc_out_d;
    logic [WID-1:0]       warp_id_q, warp_id_d;
    logic                 valid_q, valid_d;

    upd_src_e             src [NUM_WARPS];
    logic [NUM_WARPS-1:0] grant;
    logic [WID-1:0]       sel;
    logic                 any_live;
    logic                 issue;

    rr_arbiter #(
        .N   (NUM_WARPS),
        .WID (WID)
    ) u_arb (
        .req_i   (live_q),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (sel),
        .vld_o   (any_live)
    );

    assign issue = bus.en & ~bus.stall & any_live;

    always_comb begin
        live_d    = live_q;
        rr_ptr_d  = rr_ptr_q;
        pc_out_d  = pc_out_q;
        warp_id_d = warp_id_q;
        valid_d   = 1'b0;

        if (issue) begin
            pc_out_d  = pc_q[sel];
            warp_id_d = sel;
            valid_d   = 1'b1;
            rr_ptr_d  = sel + WID'(1);
        end

        for (int w = 0; w < NUM_WARPS; w++) begin
            src[w]  = UPD_HOLD;
            pc_d[w] = pc_q[w];
`ifdef PC_UNIT_LINK_EN
            link_d[w] = link_q[w];
`endif
            // Later assignments carry higher priority.
            if (issue && grant[w])
                src[w] = UPD_INC;
`ifdef PC_UNIT_LINK_EN
            if (bus.ret_valid && bus.ret_warp == WID'(w) && live_q[w])
                src[w] = UPD_RET;
`endif
            if (bus.branch_valid && bus.branch_warp == WID'(w) && live_q[w])
                src[w] = UPD_BRANCH;
            if (bus.halt_valid && bus.halt_warp == WID'(w))
                src[w] = UPD_HALT;
            if (bus.launch && bus.launch_mask[w])
                src[w] = UPD_LAUNCH;

            case (src[w])
                UPD_INC: pc_d[w] = pc_q[w] + PC_WIDTH'(1);
`ifdef PC_UNIT_LINK_EN
                UPD_RET: pc_d[w] = link_q[w];
`endif
                UPD_BRANCH: begin
                    pc_d[w] = bus.branch_target;
`ifdef PC_UNIT_LINK_EN
                    if (bus.branch_link)
                        link_d[w] = pc_q[w] + PC_WIDTH'(1);
`endif
                end
                UPD_HALT: live_d[w] = 1'b0;
                UPD_LAUNCH: begin
                    pc_d[w]   = RESET_PC;
                    live_d[w] = 1'b1;
                end
                default: pc_d[w] = pc_q[w];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= RESET_PC;
`ifdef PC_UNIT_LINK_EN
                link_q[w] <= RESET_PC;
`endif
            end
            live_q    <= '0;
            rr_ptr_q  <= '0;
            pc_out_q  <= RESET_PC;
            warp_id_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= pc_d[w];
`ifdef PC_UNIT_LINK_EN
                link_q[w] <= link_d[w];
`endif
            end
            live_q    <= live_d;
            rr_ptr_q  <= rr_ptr_d;
            pc_out_q  <= pc_out_d;
            warp_id_q <= warp_id_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.pc_out      = pc_out_q;
    assign bus.warp_id_out = warp_id_q;
    assign bus.valid_out   = valid_q;
    assign bus.idle        = ~|live_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, reset/wrap/link sequences and a
// randomized run against an array-based model of the warp PC rules.
module tb_pc_unit;

    localparam int PCW = 8;
    localparam int NW  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_unit_if #(.PC_WIDTH(PCW), .NUM_WARPS(NW)) bus ();
    pc_unit #(.PC_WIDTH(PCW), .NUM_WARPS(NW), .RESET_PC(8'h00)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    pc_unit_if #(.PC_WIDTH(4), .NUM_WARPS(NW)) bus4 ();
    pc_unit #(.PC_WIDTH(4), .NUM_WARPS(NW), .RESET_PC(4'h0)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.en = 0; bus.stall = 0; bus.launch = 0; bus.launch_mask = '0;
        bus.branch_valid = 0; bus.branch_warp = '0; bus.branch_target = '0;
        bus.halt_valid = 0; bus.halt_warp = '0;
        bus4.en = 0; bus4.stall = 0; bus4.launch = 0; bus4.launch_mask = '0;
        bus4.branch_valid = 0; bus4.branch_warp = '0; bus4.branch_target = '0;
        bus4.halt_valid = 0; bus4.halt_warp = '0;
`ifdef PC_UNIT_LINK_EN
        bus.branch_link = 0; bus.ret_valid = 0; bus.ret_warp = '0;
        bus4.branch_link = 0; bus4.ret_valid = 0; bus4.ret_warp = '0;
`endif
    endtask

    task automatic check_out(input string tag, input int v, input int w, input int p, input int i);
        check({tag, "_valid"}, int'(bus.valid_out), v);
        check({tag, "_wid"},   int'(bus.warp_id_out), w);
        check({tag, "_pc"},    int'(bus.pc_out), p);
        check({tag, "_idle"},  int'(bus.idle), i);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit       en, stall, launch;
        bit [3:0] mask;
        bit       bv;  int bw; int bt;
        bit       hv;  int hw;
        bit       ev;  int ew; int ep; bit ei;
    } vec_t;

    function automatic vec_t mk(bit en, bit st, bit la, bit [3:0] m, bit bv, int bw, int bt,
                                bit hv, int hw, bit ev, int ew, int ep, bit ei);
        vec_t v;
        v.en = en; v.stall = st; v.launch = la; v.mask = m;
        v.bv = bv; v.bw = bw; v.bt = bt; v.hv = hv; v.hw = hw;
        v.ev = ev; v.ew = ew; v.ep = ep; v.ei = ei;
        return v;
    endfunction

    vec_t tbl[$];

    // ---------------- behavioural model ----------------
    int m_pc[NW], m_live[NW], m_link[NW];
    int m_rr, m_opc, m_owid, m_oval;

    task automatic model_step();
        int npc[NW]; int nlive[NW]; int nlink[NW];
        int sel; int w; int bw; int hw;
        if (rst) begin
            for (int k = 0; k < NW; k++) begin m_pc[k] = 0; m_live[k] = 0; m_link[k] = 0; end
            m_rr = 0; m_oval = 0; m_opc = 0; m_owid = 0;
            return;
        end
        for (int k = 0; k < NW; k++) begin npc[k] = m_pc[k]; nlive[k] = m_live[k]; nlink[k] = m_link[k]; end
        sel = -1;
        if (bus.en && !bus.stall)
            for (int k = 0; k < NW; k++) begin
                w = (m_rr + k) % NW;
                if (sel < 0 && m_live[w] != 0) sel = w;
            end
        if (sel >= 0) begin
            m_opc = m_pc[sel]; m_owid = sel; m_oval = 1;
            npc[sel] = (m_pc[sel] + 1) % 256;
            m_rr = (sel + 1) % NW;
        end else m_oval = 0;
        bw = int'(bus.branch_warp);
        hw = int'(bus.halt_warp);
`ifdef PC_UNIT_LINK_EN
        if (bus.ret_valid && m_live[int'(bus.ret_warp)] != 0)
            npc[int'(bus.ret_warp)] = m_link[int'(bus.ret_warp)];
`endif
        if (bus.branch_valid && m_live[bw] != 0) begin
            npc[bw] = int'(bus.branch_target);
`ifdef PC_UNIT_LINK_EN
            if (bus.branch_link && !(bus.halt_valid && hw == bw) && !(bus.launch && bus.launch_mask[bw]))
                nlink[bw] = (m_pc[bw] + 1) % 256;
`endif
        end
        if (bus.halt_valid) begin npc[hw] = m_pc[hw]; nlive[hw] = 0; end
        if (bus.launch)
            for (int k = 0; k < NW; k++)
                if (bus.launch_mask[k]) begin npc[k] = 0; nlive[k] = 1; end
        for (int k = 0; k < NW; k++) begin m_pc[k] = npc[k]; m_live[k] = nlive[k]; m_link[k] = nlink[k]; end
    endtask

    function automatic int model_idle();
        for (int k = 0; k < NW; k++) if (m_live[k] != 0) return 0;
        return 1;
    endfunction

    initial begin
        quiet();
        rst = 1;
        tick(); tick();
        check_out("reset", 0, 0, 0, 1);
        rst = 0;

        //          en st la mask bv bw bt    hv hw | ev ew ep   ei
        tbl.push_back(mk(1,0,1,4'hF, 0,0,0,    0,0,  0,0,0,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,0,0,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,1,0,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,2,0,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,3,0,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,0,1,    0));
        tbl.push_back(mk(1,0,0,4'h0, 1,1,'h20, 0,0,  1,1,1,    0));
        tbl.push_back(mk(1,0,0,4'h0, 1,2,'h33, 1,2,  1,2,1,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,3,1,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,0,2,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,1,'h20, 0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,3,2,    0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,1,0,4'h0, 0,0,0, 0,0,  0,3,2,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,0,3,    0));
        tbl.push_back(mk(0,0,0,4'h0, 0,0,0,    1,0,  0,0,3,    0));
        tbl.push_back(mk(0,0,0,4'h0, 0,0,0,    1,1,  0,0,3,    0));
        tbl.push_back(mk(0,0,0,4'h0, 0,0,0,    1,3,  0,0,3,    1));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  0,0,3,    1));
        tbl.push_back(mk(0,0,1,4'h5, 0,0,0,    0,0,  0,0,3,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,2,0,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,0,0,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,2,1,    0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,1,0,4'h0, 0,0,0, 0,0,  0,2,1,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,0,1,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,2,2,    0));
        tbl.push_back(mk(1,0,0,4'h0, 0,0,0,    0,0,  1,0,2,    0));

        foreach (tbl[i]) begin
            bus.en = tbl[i].en; bus.stall = tbl[i].stall;
            bus.launch = tbl[i].launch; bus.launch_mask = tbl[i].mask;
            bus.branch_valid = tbl[i].bv; bus.branch_warp = 2'(tbl[i].bw);
            bus.branch_target = 8'(tbl[i].bt);
            bus.halt_valid = tbl[i].hv; bus.halt_warp = 2'(tbl[i].hw);
            tick();
            check_out($sformatf("tbl%0d", i), int'(tbl[i].ev), tbl[i].ew, tbl[i].ep, int'(tbl[i].ei));
        end
        quiet();

        // reset while issuing with a redirect pending
        bus.en = 1; bus.branch_valid = 1; bus.branch_warp = 2'd2; bus.branch_target = 8'h77;
        rst = 1;
        tick();
        check_out("midrst", 0, 0, 0, 1);
        rst = 0; quiet();
        bus.launch = 1; bus.launch_mask = 4'hF;
        tick();
        bus.launch = 0; bus.en = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("relaunch%0d", k), 1, k % NW, k / NW, 0);
        end
        quiet();

        // 4-bit PC wraps from F to 0
        bus4.launch = 1; bus4.launch_mask = 4'h1;
        tick();
        bus4.launch = 0; bus4.en = 1;
        for (int k = 0; k < 17; k++) begin
            tick();
            check($sformatf("wrap_pc%0d", k), int'(bus4.pc_out), k % 16);
            check($sformatf("wrap_vld%0d", k), int'(bus4.valid_out), 1);
        end
        quiet();

`ifdef PC_UNIT_LINK_EN
        rst = 1; tick(); rst = 0;
        bus.launch = 1; bus.launch_mask = 4'h1;
        tick();
        bus.launch = 0; bus.en = 1;
        for (int k = 0; k < 5; k++) tick();
        bus.branch_valid = 1; bus.branch_warp = 2'd0; bus.branch_target = 8'h40; bus.branch_link = 1;
        tick();
        check("link_call_pc", int'(bus.pc_out), 5);
        bus.branch_valid = 0; bus.branch_link = 0;
        bus.ret_valid = 1; bus.ret_warp = 2'd0;
        tick();
        check("link_tgt_pc", int'(bus.pc_out), 'h40);
        bus.ret_valid = 0;
        tick();
        check("link_ret_pc", int'(bus.pc_out), 6);
        quiet();
`endif

        // randomized run against the model
        rst = 1; model_step(); tick(); rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst               = ($urandom_range(0, 199) == 0);
            bus.en            = ($urandom_range(0, 7) != 0);
            bus.stall         = ($urandom_range(0, 3) == 0);
            bus.launch        = ($urandom_range(0, 9) == 0);
            bus.launch_mask   = 4'($urandom);
            bus.branch_valid  = ($urandom_range(0, 3) == 0);
            bus.branch_warp   = 2'($urandom);
            bus.branch_target = 8'($urandom);
            bus.halt_valid    = ($urandom_range(0, 7) == 0);
            bus.halt_warp     = 2'($urandom);
`ifdef PC_UNIT_LINK_EN
            bus.branch_link   = 1'($urandom);
            bus.ret_valid     = ($urandom_range(0, 5) == 0);
            bus.ret_warp      = 2'($urandom);
`endif
            model_step();
            tick();
            check_out($sformatf("rand%0d", c), m_oval, m_owid, m_opc, model_idle());
        end
        rst = 0; quiet();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
